// File: rtl/flash_write_sequencer.sv
// Flash write sequencer: buffers flasher words in a FIFO and writes them
// into instruction/data memory over req/ack ports, throttling the flasher.
module flash_write_sequencer #(
    parameter int FIFODEPTH  = 4,
    parameter int ACKTIMEOUT = 255
) (
    input  logic        clk,
    input  logic        async_rst_n,
    input  logic        clk_en,
    input  logic        InstFlashEn,
    input  logic        DataFlashEn,
    input  logic [9:0]  FlashAddr,
    input  logic [15:0] FlashData,
    input  logic        FlashComplete,
    output logic        FlasherClkEn,
    output logic        InstWriteReq,
    input  logic        InstWriteAck,
    output logic        DataWriteReq,
    input  logic        DataWriteAck,
    output logic [9:0]  WriteAddr,
    output logic [15:0] WriteData,
    output logic [15:0] Checksum,
    output logic        WriteTimeout,
    output logic        ProtocolError,
    output logic        SystemEnable
);

    localparam int AW = (FIFODEPTH > 1) ? $clog2(FIFODEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFODEPTH);
    localparam logic [15:0] TMO_C = 16'(ACKTIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INST_REQ,
        S_DATA_REQ
    } state_t;

    state_t        r_state;
    logic [AW:0]   r_count;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [26:0]   r_mem [FIFODEPTH];
    logic          r_inst_req;
    logic          r_data_req;
    logic [9:0]    r_waddr;
    logic [15:0]   r_wdata;
    logic [15:0]   r_checksum;
    logic [15:0]   r_tmo_cnt;
    logic          r_timeout;
    logic          r_proto_err;
    logic          r_sys_en;

    logic          w_flash_en;
    logic          w_push;
    logic          w_nonempty;
    logic          w_ack;
    logic          w_pop;
    logic [26:0]   w_entry;
    logic [26:0]   w_head;
    logic          w_head_isdata;

    assign FlasherClkEn  = clk_en && (r_count < DEPTH_C);
    assign w_flash_en    = InstFlashEn || DataFlashEn;
    assign w_push        = FlasherClkEn && w_flash_en;
    assign w_nonempty    = (r_count != '0);
    assign w_ack         = ((r_state == S_INST_REQ) && InstWriteAck) ||
                           ((r_state == S_DATA_REQ) && DataWriteAck);
    assign w_pop         = clk_en && w_nonempty &&
                           ((r_state == S_IDLE) || w_ack);
    // When both enables are high the word is treated as data.
    assign w_entry       = {DataFlashEn, FlashAddr, FlashData};
    assign w_head        = r_mem[r_rptr];
    assign w_head_isdata = w_head[26];

    assign InstWriteReq  = r_inst_req;
    assign DataWriteReq  = r_data_req;
    assign WriteAddr     = r_waddr;
    assign WriteData     = r_wdata;
    assign Checksum      = r_checksum;
    assign WriteTimeout  = r_timeout;
    assign ProtocolError = r_proto_err;
    assign SystemEnable  = r_sys_en;

    // FIFO storage; contents need no reset since pointers gate their use.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_entry;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (clk_en) begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Write FSM with registered requests, checksum, timeout and sticky flags.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_state     <= S_IDLE;
            r_inst_req  <= 1'b0;
            r_data_req  <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_checksum  <= '0;
            r_tmo_cnt   <= '0;
            r_timeout   <= 1'b0;
            r_proto_err <= 1'b0;
            r_sys_en    <= 1'b0;
        end else if (clk_en) begin
            if (w_push && InstFlashEn && DataFlashEn) begin
                r_proto_err <= 1'b1;
            end
            if (FlashComplete && !w_nonempty &&
                (r_state == S_IDLE) && !w_push) begin
                r_sys_en <= 1'b1;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (w_nonempty) begin
                        r_waddr    <= w_head[25:16];
                        r_wdata    <= w_head[15:0];
                        r_inst_req <= !w_head_isdata;
                        r_data_req <= w_head_isdata;
                        r_state    <= w_head_isdata ? S_DATA_REQ : S_INST_REQ;
                        r_tmo_cnt  <= '0;
                    end
                end
                S_INST_REQ, S_DATA_REQ: begin
                    if (w_ack) begin
                        r_checksum <= r_checksum + r_wdata;
                        if (w_nonempty) begin
                            r_waddr    <= w_head[25:16];
                            r_wdata    <= w_head[15:0];
                            r_inst_req <= !w_head_isdata;
                            r_data_req <= w_head_isdata;
                            r_state    <= w_head_isdata ? S_DATA_REQ
                                                        : S_INST_REQ;
                            r_tmo_cnt  <= '0;
                        end else begin
                            r_inst_req <= 1'b0;
                            r_data_req <= 1'b0;
                            r_state    <= S_IDLE;
                        end
                    end else if (r_tmo_cnt != TMO_C) begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                        if (r_tmo_cnt == TMO_C - 16'd1) begin
                            r_timeout <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_inst_req <= 1'b0;
                    r_data_req <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
